// File: rtl/rr_mux_pkg.sv
// Shared helpers for the round-robin / fixed-priority mux stage.
package rr_mux_pkg;

    localparam int unsigned MAX_N  = 64;
    localparam int unsigned MAX_NW = 6;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index of the first set bit of req[n-1:0] at or after start, wrapping; 0 if none.
    function automatic int unsigned first_set_from(
        input logic [MAX_N-1:0] req,
        input int unsigned      start,
        input int unsigned      n
    );
        int unsigned idx;
        int unsigned res;
        logic        found;
        res   = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_N; k++) begin
            if (!found && (k < n)) begin
                idx = start + k;
                if (idx >= n) idx = idx - n;
                if (req[MAX_NW'(idx)]) begin
                    res   = idx;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_mux_pick.sv
// Combinational channel picker; round-robin from ptr when ROUND_ROBIN_EN is
// defined, otherwise lowest-index fixed priority (no ptr port).
module rr_mux_pick
    import rr_mux_pkg::*;
#(
    parameter  int unsigned N    = 4,
    localparam int unsigned IDXW = idx_width(N)
) (
    input  logic [N-1:0]    req,
`ifdef ROUND_ROBIN_EN
    input  logic [IDXW-1:0] ptr,
`endif
    output logic [IDXW-1:0] gnt_idx,
    output logic            any_req
);

    always_comb begin
        any_req = |req;
`ifdef ROUND_ROBIN_EN
        gnt_idx = IDXW'(first_set_from(MAX_N'(req), int'(ptr), N));
`else
        gnt_idx = IDXW'(first_set_from(MAX_N'(req), 0, N));
`endif
    end

endmodule

// File: rtl/rr_mux_stage.sv
// N-channel valid/ready selector with one registered output stage.
// Arbitration: round-robin if ROUND_ROBIN_EN is defined, else fixed priority.
module rr_mux_stage
    import rr_mux_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned N     = 4,
    localparam int unsigned IDXW  = idx_width(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [IDXW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [IDXW-1:0]  out_sel_q,   out_sel_d;
    logic [IDXW-1:0]  gnt_idx;
    logic             any_req;
    logic             can_load;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

`ifdef ROUND_ROBIN_EN
    logic [IDXW-1:0]  ptr_q, ptr_d;
`endif

    rr_mux_pick #(.N(N)) u_pick (
        .req     (in_valid),
`ifdef ROUND_ROBIN_EN
        .ptr     (ptr_q),
`endif
        .gnt_idx (gnt_idx),
        .any_req (any_req)
    );

    // Grant decode and payload mux; nothing is accepted while rst is high.
    always_comb begin
        can_load = !out_valid_q || out_ready;
        xfer     = any_req && can_load && !rst;
        in_ready = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (IDXW'(i) == gnt_idx) begin
                in_ready[i] = xfer;
                sel_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Load replaces the held beat in the same cycle it is consumed.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
`ifdef ROUND_ROBIN_EN
        ptr_d       = ptr_q;
`endif
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_sel_d   = gnt_idx;
`ifdef ROUND_ROBIN_EN
            ptr_d       = (gnt_idx == IDXW'(N - 1)) ? '0 : gnt_idx + IDXW'(1);
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
`ifdef ROUND_ROBIN_EN
            ptr_q       <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
`ifdef ROUND_ROBIN_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_stage.sv
// Self-checking bench for rr_mux_stage (N=4 vector table, plus N=3 sequence).
module tb_rr_mux_stage;

`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    logic        rst3;
    logic [2:0]  in_valid3;
    logic [23:0] in_data3;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_sel3;
    logic        out_ready3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_mux_stage #(.WIDTH(8), .N(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_ready(out_ready)
    );

    rr_mux_stage #(.WIDTH(8), .N(3)) dut3 (
        .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_data(in_data3),
        .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3),
        .out_sel(out_sel3), .out_ready(out_ready3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] ir;
        logic       ov;
        logic [1:0] sel;
        logic [7:0] data;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];
    logic [1:0] exp3 [5];

    initial begin
        // channel payloads: ch0=C1 ch1=B2 ch2=A5 ch3=D4
        in_data   = 32'hD4A5B2C1;
        in_data3  = 24'hA5B2C1;
        rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        rst3 = 1'b1; in_valid3 = 3'b111; out_ready3 = 1'b1;

        vecs[0]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00};
        vecs[1]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00};
        vecs[2]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 8'hC1};
        vecs[3]  = '{1'b0, 4'hF, 1'b1, RR ? 4'h2 : 4'h1, 1'b1, RR ? 2'd1 : 2'd0, RR ? 8'hB2 : 8'hC1};
        vecs[4]  = '{1'b0, 4'hF, 1'b1, RR ? 4'h4 : 4'h1, 1'b1, RR ? 2'd2 : 2'd0, RR ? 8'hA5 : 8'hC1};
        vecs[5]  = '{1'b0, 4'hF, 1'b1, RR ? 4'h8 : 4'h1, 1'b1, RR ? 2'd3 : 2'd0, RR ? 8'hD4 : 8'hC1};
        vecs[6]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 8'hC1};
        vecs[7]  = '{1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA5};
        vecs[8]  = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd2, 8'hA5};
        vecs[9]  = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd2, 8'hA5};
        vecs[10] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd2, 8'hA5};
        vecs[11] = '{1'b0, 4'hF, 1'b1, RR ? 4'h8 : 4'h1, 1'b1, RR ? 2'd3 : 2'd0, RR ? 8'hD4 : 8'hC1};
        vecs[12] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, RR ? 2'd3 : 2'd0, RR ? 8'hD4 : 8'hC1};
        vecs[13] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, RR ? 2'd3 : 2'd0, RR ? 8'hD4 : 8'hC1};
        vecs[14] = '{1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA5};
        vecs[15] = '{1'b0, 4'h2, 1'b1, 4'h2, 1'b1, 2'd1, 8'hB2};
        vecs[16] = '{1'b0, 4'hF, 1'b1, RR ? 4'h4 : 4'h1, 1'b1, RR ? 2'd2 : 2'd0, RR ? 8'hA5 : 8'hC1};
        vecs[17] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, RR ? 2'd2 : 2'd0, RR ? 8'hA5 : 8'hC1};
        vecs[18] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0, 8'h00};
        vecs[19] = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 8'hC1};
        vecs[20] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 8'hC1};

        exp3[0] = 2'd0;
        exp3[1] = RR ? 2'd1 : 2'd0;
        exp3[2] = RR ? 2'd2 : 2'd0;
        exp3[3] = 2'd0;
        exp3[4] = RR ? 2'd1 : 2'd0;

        // N=4 table: drive just after an edge, check in_ready before the next
        // edge, then check the registered outputs just after it.
        @(posedge clk); #1;
        for (int v = 0; v < NV; v++) begin
            rst       = vecs[v].rst;
            in_valid  = vecs[v].iv;
            out_ready = vecs[v].ordy;
            #1;
            check($sformatf("v%0d in_ready", v), 32'(in_ready), 32'(vecs[v].ir));
            @(posedge clk); #1;
            check($sformatf("v%0d out_valid", v), 32'(out_valid), 32'(vecs[v].ov));
            check($sformatf("v%0d out_sel", v), 32'(out_sel), 32'(vecs[v].sel));
            check($sformatf("v%0d out_data", v), 32'(out_data), 32'(vecs[v].data));
        end

        // N=3: reset two cycles, then all channels valid with out_ready high.
        rst3 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("n3 rst%0d in_ready", c), 32'(in_ready3), 32'h0);
            @(posedge clk); #1;
            check($sformatf("n3 rst%0d out_valid", c), 32'(out_valid3), 32'h0);
        end
        rst3 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("n3 c%0d in_ready", c), 32'(in_ready3), 32'(3'b001 << exp3[c]));
            @(posedge clk); #1;
            check($sformatf("n3 c%0d out_valid", c), 32'(out_valid3), 32'h1);
            check($sformatf("n3 c%0d out_sel", c), 32'(out_sel3), 32'(exp3[c]));
            check($sformatf("n3 c%0d sel_range", c), 32'(out_sel3 < 2'd3), 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
